uart_debug_tx: RTL

Debug word transmitter that sits downstream of the accumulator CPU's datapath on the UART debug path. It captures each 16-bit word the CPU emits under the `wr_uart` strobe and buffers it in a small FIFO. Each word is serialized as two 8N1 bytes, high byte first, on the `tx` line. The CPU never stalls: a word offered while the FIFO is full is dropped and flagged.

---
 rtl/uart_dbg_pkg.sv | 28 ++
 rtl/dbg_word_fifo.sv | 58 +++++
 rtl/uart_debug_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_dbg_pkg.sv
// Shared types and constants for the UART debug word transmitter.
// Word framing (2 or 3 bytes) follows the UART_DBG_SYNC_EN build macro.
package uart_dbg_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         BITS_PER_BYTE = 8;

`ifdef UART_DBG_SYNC_EN
    localparam int BYTES_PER_WORD = 3;

    function automatic logic [7:0] word_byte(input logic [15:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = SYNC_BYTE;
            2'd1:    word_byte = word[15:8];
            default: word_byte = word[7:0];
        endcase
    endfunction
`else
    localparam int BYTES_PER_WORD = 2;

    function automatic logic [7:0] word_byte(input logic [15:0] word, input logic [1:0] idx);
        word_byte = (idx == 2'd0) ? word[15:8] : word[7:0];
    endfunction
`endif

endpackage

// File: rtl/dbg_word_fifo.sv
// Small synchronous word FIFO for the debug transmitter.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module dbg_word_fifo #(
    parameter int DB      = 16,
    parameter int FIFO_AW = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [DB-1:0]      i_wr_data,
    output logic [DB-1:0]      o_rd_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [FIFO_AW:0]   o_count
);

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

    logic [DB-1:0]      r_mem [0:(1 << FIFO_AW)-1];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Asynchronous read: the popping edge captures the head word with no extra latency.
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_debug_tx.sv
// Buffers 16-bit debug words and sends each as 8N1 bytes, high byte first.
// Define UART_DBG_SYNC_EN to prefix every word with the 0xA5 sync byte.
module uart_debug_tx
    import uart_dbg_pkg::*;
#(
    parameter int DB           = 16,
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_AW      = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [DB-1:0]    i_wr_data,
    input  logic             i_wr_en,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_overflow,
    output logic [FIFO_AW:0] o_fifo_count
);

    localparam int               BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(BITS_PER_BYTE - 1);
    localparam logic [1:0]        BYTE_LAST = 2'(BYTES_PER_WORD - 1);

    state_t            r_state,    w_state_next;
    logic [BAUD_W-1:0] r_baud,     w_baud_next;
    logic [2:0]        r_bit_idx,  w_bit_next;
    logic [1:0]        r_byte_idx, w_byte_next;
    logic [DB-1:0]     r_hold,     w_hold_next;
    logic [7:0]        r_shift,    w_shift_next;
    logic              r_tx,       w_tx_next;
    logic              r_overflow, w_overflow_next;

    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_baud_done;
    logic [DB-1:0]     w_fifo_data;

    dbg_word_fifo #(
        .DB      (DB),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_push    (i_wr_en),
        .i_pop     (w_pop),
        .i_wr_data (i_wr_data),
        .o_rd_data (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (o_fifo_count)
    );

    assign w_baud_done = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_idx;
        w_byte_next  = r_byte_idx;
        w_hold_next  = r_hold;
        w_shift_next = r_shift;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_hold_next  = w_fifo_data;
                    w_byte_next  = 2'd0;
                    w_shift_next = word_byte(w_fifo_data, 2'd0);
                    w_state_next = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_state_next = DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == BIT_LAST) begin
                        w_bit_next   = 3'd0;
                        w_state_next = STOP;
                    end else begin
                        w_bit_next   = r_bit_idx + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    // Next byte of this word, else next word, with no idle gap.
                    if (r_byte_idx != BYTE_LAST) begin
                        w_byte_next  = r_byte_idx + 2'd1;
                        w_shift_next = word_byte(r_hold, r_byte_idx + 2'd1);
                        w_state_next = START;
                    end else if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_hold_next  = w_fifo_data;
                        w_byte_next  = 2'd0;
                        w_shift_next = word_byte(w_fifo_data, 2'd0);
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase

        w_overflow_next = r_overflow | (i_wr_en & w_full & ~w_pop);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_hold     <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_byte_idx <= w_byte_next;
            r_hold     <= w_hold_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign o_tx       = r_tx;
    assign o_overflow = r_overflow;
    assign o_busy     = !w_empty || (r_state != IDLE);

endmodule
